// File: rtl/pulse_gen.sv
// Strobe-to-pulse generator: fixed-width pulses with a guaranteed low gap between them.
// Optional request queue enabled by defining PULSE_GEN_QUEUE_EN.
module pulse_gen #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned LOW_CYCLES  = 2,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stb_i,
  output logic              pulse_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              drop_o
);

  localparam int unsigned CntMax = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

`ifdef PULSE_GEN_QUEUE_EN
  localparam bit QueueEn = 1'b1;
`else
  localparam bit QueueEn = 1'b0;
`endif

  localparam logic [CntW-1:0]   CntHigh = CntW'(HIGH_CYCLES - 1);
  localparam logic [CntW-1:0]   CntLow  = CntW'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [PEND_W-1:0] r_pend, w_pend_d;
  logic              r_pulse, r_busy, r_drop, w_drop_d;
  logic              w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pend_d  = r_pend;
    w_drop_d  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (stb_i) begin
          w_state_d = StHigh;
          w_cnt_d   = CntHigh;
        end
      end

      StHigh: begin
        if (w_cnt_zero) begin
          w_state_d = StLow;
          w_cnt_d   = CntLow;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end

      StLow: begin
        if (w_cnt_zero) begin
          if (QueueEn && (r_pend != '0)) begin
            w_state_d = StHigh;
            w_cnt_d   = CntHigh;
          end else if (stb_i) begin
            w_state_d = StHigh;
            w_cnt_d   = CntHigh;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase

    // Final LOW cycle: a strobe either starts the next pulse directly or cancels the dequeue.
    if (r_state == StLow && w_cnt_zero) begin
      if (QueueEn && (r_pend != '0) && !stb_i) begin
        w_pend_d = r_pend - PendOne;
      end
    end else if (r_state != StIdle && stb_i) begin
      if (QueueEn && (r_pend != PendMax)) begin
        w_pend_d = r_pend + PendOne;
      end else begin
        w_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pend  <= w_pend_d;
      r_pulse <= (w_state_d == StHigh);
      r_busy  <= (w_state_d != StIdle);
      r_drop  <= w_drop_d;
    end
  end

  assign pulse_o   = r_pulse;
  assign busy_o    = r_busy;
  assign pending_o = r_pend;
  assign drop_o    = r_drop;

endmodule
